// File: rtl/core_inst_sequencer.sv
// Sequences the 34-bit core instruction bus through one full convolution layer:
// per-kij weight/activation loads, execute, OFIFO writeback, then output accumulation.
module core_inst_sequencer #(
    parameter int COL   = 8,
    parameter int IN_W  = 8,
    parameter int K     = 3,
    parameter int WBASE = 1024,
    parameter int GAP   = 10,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          acc_clr,
    output logic          out_valid,
    output logic [AW-1:0] onij,
    output logic          busy,
    output logic          done
);
    localparam int KK = K * K;
    localparam int CW = AW + 2;
    localparam int KW = $clog2(KK + 1);
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    if (AW != 11) begin : g_bad_aw
        $error("core_inst_sequencer: instruction layout needs 11-bit addresses");
    end
    if ((IN_W % 2) != 0) begin : g_bad_inw
        $error("core_inst_sequencer: IN_W must be even");
    end
    if ((IN_W / 2) < K) begin : g_bad_k
        $error("core_inst_sequencer: kernel larger than half-width feature map");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("core_inst_sequencer: GAP must be at least 1");
    end
    if (KK * IN_W * IN_W + IN_W * IN_W > (1 << AW)) begin : g_bad_pmem
        $error("core_inst_sequencer: PMEM region exceeds address space");
    end
    if (WBASE + 2 * COL > (1 << AW)) begin : g_bad_wbase
        $error("core_inst_sequencer: weight region exceeds address space");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WL0, S_LOAD, S_GAP, S_AL0, S_EXEC, S_DRAIN, S_OFRD, S_ACC, S_DONE
    } state_t;

    typedef struct packed {
        logic [33:0]   inst;
        logic          acc_clr;
        logic          out_valid;
        logic [AW-1:0] onij;
        logic          busy;
        logic          done;
    } outs_t;

    localparam outs_t IDLE_OUTS = '{inst: IDLE_INST, acc_clr: 1'b0, out_valid: 1'b0,
                                    onij: '0, busy: 1'b0, done: 1'b0};

    function automatic int dimW(input logic m);
        return m ? IN_W / 2 : IN_W;
    endfunction

    function automatic int dimWr(input logic m);
        return m ? 2 * COL : COL;
    endfunction

    // Output decode for a given state/counter snapshot; evaluated on next-state
    // values so every output leaves a flop aligned with the state it belongs to.
    function automatic outs_t decode(input state_t s, input int c, input int kij,
                                     input int o, input int oy, input int ox,
                                     input logic m);
        outs_t r;
        logic acc, cenP, wenP, cenX, wenX, ofRd, l0Rd, l0Wr, exe, ld;
        logic [AW-1:0] aP, aX;
        int w, nij, wr, k;
        w    = dimW(m);
        nij  = w * w;
        wr   = dimWr(m);
        k    = c - 1;
        acc  = 1'b0;
        cenP = 1'b1;
        wenP = 1'b1;
        cenX = 1'b1;
        wenX = 1'b1;
        ofRd = 1'b0;
        l0Rd = 1'b0;
        l0Wr = 1'b0;
        exe  = 1'b0;
        ld   = 1'b0;
        aP   = '0;
        aX   = '0;
        r    = '0;
        case (s)
            S_WL0: begin
                if (c < wr) begin
                    cenX = 1'b0;
                    aX   = AW'(WBASE + c);
                end
                l0Wr = (c >= 1);
            end
            S_LOAD: begin
                l0Rd = 1'b1;
                ld   = 1'b1;
            end
            S_AL0: begin
                if (c < nij) begin
                    cenX = 1'b0;
                    aX   = AW'(c);
                end
                l0Wr = (c >= 1);
            end
            S_EXEC: begin
                l0Rd = 1'b1;
                exe  = 1'b1;
            end
            S_OFRD: begin
                ofRd = (c < nij);
                if (c >= 1) begin
                    cenP = 1'b0;
                    wenP = 1'b0;
                    aP   = AW'(kij * nij + k);
                end
            end
            S_ACC: begin
                r.acc_clr = (c == 0);
                if (c >= 1 && c <= KK) begin
                    cenP = 1'b0;
                    aP   = AW'(k * nij + (oy + k / K) * w + ox + k % K);
                end
                acc = (c >= 2 && c <= KK + 1);
                if (c == KK + 2) begin
                    r.out_valid = 1'b1;
                    r.onij      = AW'(o);
                end
            end
            S_DONE: r.done = 1'b1;
            default: ;
        endcase
        r.busy = (s != S_IDLE) && (s != S_DONE);
        r.inst = {acc, cenP, wenP, aP, cenX, wenX, aX, ofRd, 1'b0, 1'b0, l0Rd, l0Wr, exe, ld};
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] kij_q, kij_d;
    logic [AW-1:0] o_q, o_d, oy_q, oy_d, ox_q, ox_d;
    logic          mode_q, mode_d;
    outs_t         outs_q, outs_d;

    int nijCur, wrCur, owCur, nonijCur, cntNow, kijNow, oNow, oxNow;

    assign nijCur   = dimW(mode_q) * dimW(mode_q);
    assign wrCur    = dimWr(mode_q);
    assign owCur    = dimW(mode_q) - K + 1;
    assign nonijCur = owCur * owCur;
    assign cntNow   = int'(cnt_q);
    assign kijNow   = int'(kij_q);
    assign oNow     = int'(o_q);
    assign oxNow    = int'(ox_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        kij_d   = kij_q;
        o_d     = o_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_WL0;
                    mode_d  = mode;
                    kij_d   = '0;
                end
            end
            S_WL0: if (cntNow == wrCur) begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
            S_LOAD: if (cntNow == 2 * wrCur - 1) begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: if (cntNow == GAP - 1) begin
                state_d = S_AL0;
                cnt_d   = '0;
            end
            S_AL0: if (cntNow == nijCur) begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: if (cntNow == nijCur - 1) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            // The drain counter saturates: only the minimum wait matters, the
            // exit itself is open-ended on ofifo_valid.
            S_DRAIN: begin
                if (cntNow >= GAP - 1 && ofifo_valid) begin
                    state_d = S_OFRD;
                    cnt_d   = '0;
                end else if (cntNow >= GAP) begin
                    cnt_d = cnt_q;
                end
            end
            S_OFRD: if (cntNow == nijCur) begin
                cnt_d = '0;
                kij_d = kij_q + 1'b1;
                if (kijNow == KK - 1) begin
                    state_d = S_ACC;
                    o_d     = '0;
                    oy_d    = '0;
                    ox_d    = '0;
                end else begin
                    state_d = S_WL0;
                end
            end
            S_ACC: if (cntNow == KK + 2) begin
                cnt_d = '0;
                if (oNow == nonijCur - 1) begin
                    state_d = S_DONE;
                end else begin
                    o_d = o_q + 1'b1;
                    if (oxNow == owCur - 1) begin
                        ox_d = '0;
                        oy_d = oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign outs_d = decode(state_d, int'(cnt_d), int'(kij_d), int'(o_d),
                           int'(oy_d), int'(ox_d), mode_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            o_q     <= '0;
            oy_q    <= '0;
            ox_q    <= '0;
            mode_q  <= 1'b0;
            outs_q  <= IDLE_OUTS;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            o_q     <= o_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            mode_q  <= mode_d;
            outs_q  <= outs_d;
        end
    end

    assign inst      = outs_q.inst;
    assign acc_clr   = outs_q.acc_clr;
    assign out_valid = outs_q.out_valid;
    assign onij      = outs_q.onij;
    assign busy      = outs_q.busy;
    assign done      = outs_q.done;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench: a loop-built expected per-cycle trace of the layer,
// driven with random input noise, plus spot checks of key addresses and counts.
module tb_core_inst_sequencer;
    localparam int COL   = 8;
    localparam int IN_W  = 8;
    localparam int K     = 3;
    localparam int KK    = K * K;
    localparam int WBASE = 1024;
    localparam int GAP   = 10;
    localparam int AW    = 11;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [33:0]   inst;
    logic          acc_clr;
    logic          out_valid;
    logic [AW-1:0] onij;
    logic          busy;
    logic          done;

    core_inst_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .onij       (onij),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [33:0]   inst;
        logic          accClr;
        logic          outValid;
        logic [AW-1:0] onij;
        logic          busy;
        logic          done;
        logic          start;
        logic          mode;
        logic          ofv;
    } entry_t;

    entry_t trace[$];
    int     testCount = 0;
    int     failCount = 0;
    bit     startNoise = 1'b0;
    int     drainRiseIdx, exec1Idx, firstOfrd, doneCnt, loadCnt;
    int     pWr[$];
    int     pRd[$];
    int     xRd[$];
    int     onijSeen[$];

    // Instruction word assembled field by field from the bus layout.
    function automatic logic [33:0] mkInst(input bit acc, input bit cenP, input bit wenP,
                                           input int aP, input bit cenX, input bit wenX,
                                           input int aX, input bit ofRd, input bit l0Rd,
                                           input bit l0Wr, input bit exe, input bit ld);
        logic [10:0] p, x;
        p = 11'(aP);
        x = 11'(aX);
        return {acc, cenP, wenP, p, cenX, wenX, x, ofRd, 1'b0, 1'b0, l0Rd, l0Wr, exe, ld};
    endfunction

    function automatic entry_t mkEntry(input logic [33:0] i, input bit b);
        entry_t e;
        e          = '0;
        e.inst     = i;
        e.busy     = b;
        e.start    = startNoise ? ($urandom_range(0, 7) == 0) : 1'b0;
        e.mode     = 1'($urandom_range(0, 1));
        e.ofv      = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic add_idle(input int n);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            e       = mkEntry(IDLE_INST, 1'b0);
            e.start = 1'b0;
            trace.push_back(e);
        end
    endtask

    // Expected cycles of one layer, starting with the IDLE cycle that carries start.
    task automatic build_layer(input logic m, input int drainHold);
        int w, nij, wr, ow, nonij, L, oy, ox, k, ap;
        bit rd;
        entry_t e;
        w     = m ? IN_W / 2 : IN_W;
        nij   = w * w;
        wr    = m ? 2 * COL : COL;
        ow    = w - K + 1;
        nonij = ow * ow;
        e       = mkEntry(IDLE_INST, 1'b0);
        e.start = 1'b1;
        e.mode  = m;
        trace.push_back(e);
        for (int kij = 0; kij < KK; kij++) begin
            for (int c = 0; c <= wr; c++)
                trace.push_back(mkEntry(mkInst(1'b0, 1'b1, 1'b1, 0, !(c < wr), 1'b1,
                                (c < wr) ? WBASE + c : 0, 1'b0, 1'b0, c >= 1, 1'b0, 1'b0), 1'b1));
            for (int c = 0; c < 2 * wr; c++)
                trace.push_back(mkEntry(mkInst(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0,
                                1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b1));
            for (int c = 0; c < GAP; c++)
                trace.push_back(mkEntry(IDLE_INST, 1'b1));
            for (int c = 0; c <= nij; c++)
                trace.push_back(mkEntry(mkInst(1'b0, 1'b1, 1'b1, 0, !(c < nij), 1'b1,
                                (c < nij) ? c : 0, 1'b0, 1'b0, c >= 1, 1'b0, 1'b0), 1'b1));
            for (int c = 0; c < nij; c++) begin
                if (kij == 1 && c == nij / 2) exec1Idx = trace.size();
                trace.push_back(mkEntry(mkInst(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1));
            end
            L = (drainHold > 0 && kij == 0) ? drainHold : GAP - 1 + $urandom_range(0, 12);
            for (int c = 0; c <= L; c++) begin
                e = mkEntry(IDLE_INST, 1'b1);
                if (!(c < GAP - 1 && drainHold == 0)) e.ofv = (c == L);
                if (kij == 0 && c == L) drainRiseIdx = trace.size();
                trace.push_back(e);
            end
            for (int c = 0; c <= nij; c++)
                trace.push_back(mkEntry(mkInst(1'b0, !(c >= 1), !(c >= 1),
                                (c >= 1) ? kij * nij + c - 1 : 0, 1'b1, 1'b1, 0,
                                c < nij, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1));
        end
        for (int o = 0; o < nonij; o++) begin
            oy = o / ow;
            ox = o % ow;
            for (int cy = 0; cy <= KK + 2; cy++) begin
                k  = cy - 1;
                rd = (cy >= 1 && cy <= KK);
                ap = rd ? k * nij + (oy + k / K) * w + ox + k % K : 0;
                e  = mkEntry(mkInst(cy >= 2 && cy <= KK + 1, !rd, 1'b1, ap, 1'b1, 1'b1, 0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
                e.accClr = (cy == 0);
                if (cy == KK + 2) begin
                    e.outValid = 1'b1;
                    e.onij     = 11'(o);
                end
                trace.push_back(e);
            end
        end
        e      = mkEntry(IDLE_INST, 1'b0);
        e.done = 1'b1;
        trace.push_back(e);
    endtask

    // Walks the trace one cycle at a time; entered and left at #1 after a posedge.
    task automatic run_trace(input int limit, input string name);
        int n, printed;
        entry_t e;
        n       = (limit < trace.size()) ? limit : trace.size();
        printed = 0;
        firstOfrd = -1;
        doneCnt = 0;
        loadCnt = 0;
        pWr.delete();
        pRd.delete();
        xRd.delete();
        onijSeen.delete();
        for (int i = 0; i < n; i++) begin
            e           = trace[i];
            start       = e.start;
            mode        = e.mode;
            ofifo_valid = e.ofv;
            testCount++;
            if (inst !== e.inst || acc_clr !== e.accClr || out_valid !== e.outValid ||
                onij !== e.onij || busy !== e.busy || done !== e.done) begin
                failCount++;
                if (printed < 8) begin
                    printed++;
                    $display("[TB] FAIL %s cycle %0d: got inst=%h clr=%b ov=%b onij=%0d busy=%b done=%b, want inst=%h clr=%b ov=%b onij=%0d busy=%b done=%b",
                             name, i, inst, acc_clr, out_valid, onij, busy, done,
                             e.inst, e.accClr, e.outValid, e.onij, e.busy, e.done);
                end
            end
            if (inst[32] === 1'b0 && inst[31] === 1'b0) pWr.push_back(int'(inst[30:20]));
            if (inst[32] === 1'b0 && inst[31] === 1'b1) pRd.push_back(int'(inst[30:20]));
            if (inst[19] === 1'b0) xRd.push_back(int'(inst[17:7]));
            if (inst[6] === 1'b1 && firstOfrd < 0) firstOfrd = i;
            if (inst[0] === 1'b1) loadCnt++;
            if (out_valid === 1'b1) onijSeen.push_back(int'(onij));
            if (done === 1'b1) doneCnt++;
            @(posedge clk);
            #1;
        end
        start       = 1'b0;
        ofifo_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        testCount++;
        if (inst !== IDLE_INST || acc_clr !== 1'b0 || out_valid !== 1'b0 || onij !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_state: got inst=%h clr=%b ov=%b onij=%0d busy=%b done=%b, want inst=%h and zeros",
                     inst, acc_clr, out_valid, onij, busy, done, IDLE_INST);
        end
        reset = 1'b0;
    endtask

    task automatic test_mode0_layer();
        bit ok;
        trace.delete();
        startNoise = 1'b0;
        build_layer(1'b0, 0);
        add_idle(2);
        run_trace(trace.size(), "mode0");
        ok = (pWr.size() == KK * 64);
        for (int i = 0; i < pWr.size() && ok; i++) if (pWr[i] != i) ok = 1'b0;
        testCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL mode0_pmem_writes: got %0d writes (need 576 in order 0..575)", pWr.size());
        end
        ok = (onijSeen.size() == 36);
        for (int i = 0; i < onijSeen.size() && ok; i++) if (onijSeen[i] != i) ok = 1'b0;
        testCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL mode0_out_valid: got %0d pulses (need 36, onij 0..35)", onijSeen.size());
        end
        testCount++;
        if (doneCnt != 1) begin
            failCount++;
            $display("[TB] FAIL mode0_done: got %0d done pulses, want 1", doneCnt);
        end
        testCount++;
        if (pRd.size() < 324 || pRd[4] != 265 || pRd[323] != 575 || pRd[63] != 9) begin
            failCount++;
            $display("[TB] FAIL mode0_acc_addr: got %0d reads, o0k4/o35k8/o7k0=%0d/%0d/%0d, want 265/575/9",
                     pRd.size(), (pRd.size() > 4) ? pRd[4] : -1,
                     (pRd.size() > 323) ? pRd[323] : -1, (pRd.size() > 63) ? pRd[63] : -1);
        end
        testCount++;
        if (loadCnt != KK * 2 * COL) begin
            failCount++;
            $display("[TB] FAIL mode0_load_cycles: got %0d, want %0d", loadCnt, KK * 2 * COL);
        end
    endtask

    task automatic test_drain_hold();
        trace.delete();
        startNoise = 1'b0;
        build_layer(1'b0, 50);
        run_trace(exec1Idx + 1, "drain");
        testCount++;
        if (firstOfrd != drainRiseIdx + 1) begin
            failCount++;
            $display("[TB] FAIL drain_first_ofifo_rd: got cycle %0d, want %0d", firstOfrd, drainRiseIdx + 1);
        end
    endtask

    task automatic test_reset_midexec();
        testCount++;
        if (inst[1] !== 1'b1 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset_exec: got execute=%b busy=%b, want 1/1", inst[1], busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            testCount++;
            if (inst !== IDLE_INST || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
                acc_clr !== 1'b0 || onij !== '0) begin
                failCount++;
                $display("[TB] FAIL reset_midexec cycle %0d: got inst=%h busy=%b done=%b ov=%b, want inst=%h and zeros",
                         i, inst, busy, done, out_valid, IDLE_INST);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_mode1_layer();
        bit ok;
        trace.delete();
        startNoise = 1'b1;
        build_layer(1'b1, 0);
        add_idle(2);
        run_trace(trace.size(), "mode1");
        ok = (xRd.size() >= 16);
        for (int i = 0; i < 16 && ok; i++) if (xRd[i] != WBASE + i) ok = 1'b0;
        testCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL mode1_weight_reads: got %0d reads, first=%0d, want 1024..1039",
                     xRd.size(), (xRd.size() > 0) ? xRd[0] : -1);
        end
        testCount++;
        if (loadCnt != KK * 32) begin
            failCount++;
            $display("[TB] FAIL mode1_load_cycles: got %0d, want %0d", loadCnt, KK * 32);
        end
        testCount++;
        if (onijSeen.size() != 4 || doneCnt != 1) begin
            failCount++;
            $display("[TB] FAIL mode1_outputs: got %0d pulses %0d done, want 4 pulses 1 done", onijSeen.size(), doneCnt);
        end
        testCount++;
        if (pRd.size() != 36 || pRd[35] != 143) begin
            failCount++;
            $display("[TB] FAIL mode1_acc_addr: got %0d reads, o3k8=%0d, want 36 reads and 143",
                     pRd.size(), (pRd.size() > 35) ? pRd[35] : -1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        trace.delete();
        startNoise = 1'b1;
        build_layer(1'b0, 0);
        build_layer(1'b1, 0);
        add_idle(2);
        run_trace(trace.size(), "back_to_back");
        testCount++;
        if (doneCnt != 2) begin
            failCount++;
            $display("[TB] FAIL b2b_done: got %0d done pulses, want 2", doneCnt);
        end
        ok = (onijSeen.size() == 40);
        for (int i = 0; i < onijSeen.size() && ok; i++)
            if (onijSeen[i] != ((i < 36) ? i : i - 36)) ok = 1'b0;
        testCount++;
        if (!ok) begin
            failCount++;
            $display("[TB] FAIL b2b_onij: got %0d pulses, want 40 (0..35 then 0..3)", onijSeen.size());
        end
    endtask

    initial begin
        test_reset();
        test_mode0_layer();
        test_drain_hold();
        test_reset_midexec();
        test_mode1_layer();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
